alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle 32-bit ALU.
- Adds AND/OR plus iterative unsigned multiply and divide.
- Registers the result and flags.
- Sits between the register-file read stage and writeback, using valid/ready on both sides so multi-cycle ops can stall the datapath.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
MULDIV_EN, 1, 1 = ops 110/111 iterate; 0 = they complete in 1 cycle with result 0
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operands/op presented
in_ready  output  1  block can accept an operation this cycle
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
op_sel  input  3  000 add, 001 sub, 010 xor, 011 slt (unsigned), 100 and, 101 or, 110 mul (low WIDTH bits), 111 divu (quotient)
out_valid  output  1  result/flags valid
out_ready  input  1  consumer takes result
result  output  WIDTH  registered result
overflow  output  1  signed overflow, add/sub only, else 0
carry  output  1  add: carry out; sub: borrow (A<B unsigned); else 0
negative  output  1  result[WIDTH-1]
zero  output  1  result == 0
div_by_zero  output  1  op 111 with op_b == 0
busy  output  1  high in CALC state

Behaviour:
- Reset (async):
  - state=IDLE; result=0; all flags=0; out_valid=0; in_ready=1; busy=0.
  - Counter and operand/accumulator registers are cleared.
  - Reset mid-CALC or mid-HOLD aborts the operation; no output is produced.
- FSM states IDLE, CALC, HOLD:
  - in_ready = (state==IDLE).
  - out_valid = (state==HOLD).
- IDLE:
  - Accept occurs on in_valid && in_ready.
  - Operands and op_sel are captured at accept; later input changes are ignored.
  - Single-cycle ops (000-101, or 110/111 with MULDIV_EN=0): result and flags are computed and registered at the accept edge; next state HOLD. out_valid is high the cycle after accept (latency 1).
  - mul/divu with MULDIV_EN=1: load counter=WIDTH; next state CALC.
- CALC, one iteration per cycle:
  - mul: shift-add. If multiplier LSB is 1, add the multiplicand to the accumulator; then shift the multiplicand left and the multiplier right. Keep the low WIDTH bits.
  - divu: restoring. Shift {rem,quot} left 1; if rem>=B, subtract B and set the quotient LSB.
  - The counter decrements each cycle; on the cycle it is 1, final result/flags are registered and next state is HOLD.
  - out_valid first high WIDTH+1 cycles after the accept edge.
- Divide by zero: result = all ones, div_by_zero=1. Still takes the full WIDTH iterations, which keeps latency fixed.
- HOLD:
  - result/flags are held stable until out_valid && out_ready; then next state IDLE.
  - No new accept in the same cycle; back-to-back throughput is 1 op per 2 cycles for single-cycle ops.
- Arithmetic:
  - add/sub are WIDTH+1 wide internally; the MSB gives carry/borrow.
  - overflow(add) = A[msb]==B[msb] && R[msb]!=A[msb].
  - overflow(sub) = A[msb]!=B[msb] && R[msb]!=A[msb].
  - slt is an unsigned compare giving 1 or 0.
  - zero and negative are derived from the registered result for every op.
  - div_by_zero is 0 for all ops except 111.
- out_ready while not in HOLD is ignored. in_valid while not in IDLE is ignored; the producer must hold its request.

Test Plan:
- Reset then add, WIDTH=32: A=0x7FFFFFFF, B=1 -> 1 cycle later out_valid, result=0x80000000, overflow=1, negative=1, carry=0, zero=0.
- sub A=5, B=5 -> result 0, zero=1, carry=0. Then sub A=3, B=5 -> result 0xFFFFFFFE, carry=1, negative=1, overflow=0.
- mul A=0x0001_0003, B=0x0000_0005 -> busy for 32 cycles, out_valid at cycle 33 after accept, result=0x0005_000F. Holding out_ready=0 for 5 cycles keeps result stable and in_ready=0.
- divu A=100, B=7 -> result 14 at cycle 33. divu A=9, B=0 -> result 0xFFFFFFFF, div_by_zero=1.
- Reset asserted on cycle 10 of a mul -> outputs immediately 0, out_valid=0, in_ready=1. A following xor 0xF0F0 ^ 0xFFFF returns 0x0F0F.
- WIDTH=8, MULDIV_EN=0: slt 0x80 < 0x7F -> 0 (unsigned); mul -> result 0 after 1 cycle, busy never asserts.

Source files
------------

// File: rtl/alu_seq_if.sv
// Handshaked operand/result bus between the register-read stage and the sequential ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             carry;
  logic             negative;
  logic             zero;
  logic             div_by_zero;
  logic             busy;

  // Producer of operations / consumer of results.
  modport master (
    output in_valid, op_a, op_b, op_sel, out_ready,
    input  in_ready, out_valid, result, overflow, carry, negative, zero,
           div_by_zero, busy
  );

  // The ALU itself.
  modport slave (
    input  in_valid, op_a, op_b, op_sel, out_ready,
    output in_ready, out_valid, result, overflow, carry, negative, zero,
           div_by_zero, busy
  );

endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/xor/slt/and/or, iterative unsigned
// multiply (shift-add) and divide (restoring), registered result and flags,
// valid/ready on both the operand and the result side.
module alu_seq #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MULDIV_EN = 1'b1,
  localparam int unsigned CNT_W    = $clog2(WIDTH + 1)
) (
  input logic       clk,
  input logic       reset,
  alu_seq_if.slave  bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             div_q, div_next;
  logic [WIDTH-1:0] a_q, a_next;
  logic [WIDTH-1:0] b_q, b_next;
  logic [WIDTH-1:0] acc, acc_next;

  logic [WIDTH-1:0] result_q, result_next;
  logic             ovf_q, ovf_next;
  logic             carry_q, carry_next;
  logic             neg_q, neg_next;
  logic             zero_q, zero_next;
  logic             dbz_q, dbz_next;

  logic             in_ready_q, out_valid_q, busy_q;

  // Single-cycle datapath on the live inputs (used only at the accept edge).
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v;

  // Iteration datapath on the captured operands.
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_new;
  logic [WIDTH-1:0] quot_new;
  logic [WIDTH-1:0] iter_r;

  logic             is_iter;

  // State and datapath registers; handshake outputs are registered from next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      div_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc         <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      carry_q     <= 1'b0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      div_q       <= div_next;
      a_q         <= a_next;
      b_q         <= b_next;
      acc         <= acc_next;
      result_q    <= result_next;
      ovf_q       <= ovf_next;
      carry_q     <= carry_next;
      neg_q       <= neg_next;
      zero_q      <= zero_next;
      dbz_q       <= dbz_next;
      in_ready_q  <= (state_next == IDLE);
      out_valid_q <= (state_next == HOLD);
      busy_q      <= (state_next == CALC);
    end
  end

  // Single-cycle op result and add/sub flags from the presented operands.
  always_comb begin
    sum   = {1'b0, bus.op_a} + {1'b0, bus.op_b};
    diff  = {1'b0, bus.op_a} - {1'b0, bus.op_b};
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    unique case (bus.op_sel)
      OP_ADD: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &&
                (sum[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
        alu_v = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &&
                (diff[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      OP_XOR:  alu_r = bus.op_a ^ bus.op_b;
      OP_SLT:  alu_r = WIDTH'(bus.op_a < bus.op_b);
      OP_AND:  alu_r = bus.op_a & bus.op_b;
      OP_OR:   alu_r = bus.op_a | bus.op_b;
      default: alu_r = '0;
    endcase
  end

  // One shift-add or restoring-divide step on the captured operands.
  always_comb begin
    mul_acc  = b_q[0] ? (acc + a_q) : acc;
    rem_sh   = {acc, a_q[WIDTH-1]};
    rem_ge   = rem_sh[WIDTH] || (rem_sh[WIDTH-1:0] >= b_q);
    rem_new  = rem_ge ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
    quot_new = {a_q[WIDTH-2:0], rem_ge};
    if (div_q) begin
      iter_r = (b_q == '0) ? '1 : quot_new;
    end else begin
      iter_r = mul_acc;
    end
  end

  // Next-state and register-update logic for the IDLE/CALC/HOLD sequencer.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    div_next    = div_q;
    a_next      = a_q;
    b_next      = b_q;
    acc_next    = acc;
    result_next = result_q;
    ovf_next    = ovf_q;
    carry_next  = carry_q;
    neg_next    = neg_q;
    zero_next   = zero_q;
    dbz_next    = dbz_q;
    is_iter     = MULDIV_EN && (bus.op_sel[2:1] == 2'b11);

    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          div_next = bus.op_sel[0];
          a_next   = bus.op_a;
          b_next   = bus.op_b;
          acc_next = '0;
          if (is_iter) begin
            cnt_next   = CNT_W'(WIDTH);
            state_next = CALC;
          end else begin
            result_next = alu_r;
            ovf_next    = alu_v;
            carry_next  = alu_c;
            neg_next    = alu_r[WIDTH-1];
            zero_next   = (alu_r == '0);
            dbz_next    = (bus.op_sel == 3'b111) && (bus.op_b == '0);
            state_next  = HOLD;
          end
        end
      end

      CALC: begin
        cnt_next = cnt - CNT_W'(1);
        if (div_q) begin
          acc_next = rem_new;
          a_next   = quot_new;
        end else begin
          acc_next = mul_acc;
          a_next   = a_q << 1;
          b_next   = b_q >> 1;
        end
        if (cnt == CNT_W'(1)) begin
          result_next = iter_r;
          ovf_next    = 1'b0;
          carry_next  = 1'b0;
          neg_next    = iter_r[WIDTH-1];
          zero_next   = (iter_r == '0);
          dbz_next    = div_q && (b_q == '0);
          state_next  = HOLD;
        end
      end

      HOLD: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
  assign bus.result      = result_q;
  assign bus.overflow    = ovf_q;
  assign bus.carry       = carry_q;
  assign bus.negative    = neg_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;

endmodule
